// File: rtl/remote_cmd_sequencer.sv
// Table-driven command player for a RemoteComm master: plays (cmd, data, settle)
// entries, checks each response against ACK, with timeout, abort and loop passes.
module remote_cmd_sequencer #(
  parameter int          DEPTH   = 16,
  parameter int          CMD_W   = 8,
  parameter int          DATA_W  = 16,
  parameter int          DLY_W   = 24,
  parameter int          TMO_CYC = 2000000,
  parameter logic [7:0]  ACK     = 8'hA5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [CMD_W-1:0]           wr_cmd,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [DLY_W-1:0]           wr_dly,
  input  logic [$clog2(DEPTH):0]     num_entries,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       loop_en,
  output logic [CMD_W-1:0]           host_cmd,
  output logic [DATA_W-1:0]          data,
  output logic                       send_cmd,
  input  logic                       cmd_sent,
  input  logic                       resp_rdy,
  input  logic [7:0]                 resp,
  output logic                       clr_resp_rdy,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [1:0]                 err_code,
  output logic [$clog2(DEPTH)-1:0]   cur_idx,
  output logic [15:0]                pass_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TMO_CYC) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_LOAD      = 4'd1;
  localparam logic [3:0] S_SEND      = 4'd2;
  localparam logic [3:0] S_WAIT_SENT = 4'd3;
  localparam logic [3:0] S_WAIT_RESP = 4'd4;
  localparam logic [3:0] S_CHECK     = 4'd5;
  localparam logic [3:0] S_SETTLE    = 4'd6;
  localparam logic [3:0] S_DONE      = 4'd7;
  localparam logic [3:0] S_ERR       = 4'd8;

  logic [CMD_W-1:0]  tbl_cmd [DEPTH];
  logic [DATA_W-1:0] tbl_dat [DEPTH];
  logic [DLY_W-1:0]  tbl_dly [DEPTH];

  logic [3:0]        state_q, state_d;
  logic [CMD_W-1:0]  cmd_q, cmd_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic [DLY_W-1:0]  dly_q, dly_d, dly_cnt_q, dly_cnt_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [7:0]        resp_q, resp_d;
  logic [AW:0]       num_q, num_d;
  logic              loop_q, loop_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [15:0]       pass_q, pass_d;
  logic              done_q, done_d, err_q, err_d;
  logic [1:0]        code_q, code_d;
  logic              last;

  // Table storage has no reset; writes are locked out during playback.
  always_ff @(posedge clk) begin
    if (wr_en && !busy) begin
      tbl_cmd[wr_addr] <= wr_cmd;
      tbl_dat[wr_addr] <= wr_data;
      tbl_dly[wr_addr] <= wr_dly;
    end
  end

  assign busy = !(state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
  assign last = ({1'b0, idx_q} == (num_q - (AW+1)'(1)));

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    dat_d     = dat_q;
    dly_d     = dly_q;
    dly_cnt_d = dly_cnt_q;
    tmo_d     = tmo_q;
    resp_d    = resp_q;
    num_d     = num_q;
    loop_d    = loop_q;
    idx_d     = idx_q;
    pass_d    = pass_q;
    done_d    = done_q;
    err_d     = err_q;
    code_d    = code_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          idx_d  = '0;
          pass_d = '0;
          err_d  = 1'b0;
          code_d = 2'b00;
          if (num_entries == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            num_d   = num_entries;
            loop_d  = loop_en;
            done_d  = 1'b0;
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        cmd_d   = tbl_cmd[idx_q];
        dat_d   = tbl_dat[idx_q];
        dly_d   = tbl_dly[idx_q];
        state_d = S_SEND;
      end
      S_SEND: state_d = S_WAIT_SENT;
      S_WAIT_SENT: begin
        if (cmd_sent) begin
          tmo_d   = '0;
          state_d = S_WAIT_RESP;
        end
      end
      S_WAIT_RESP: begin
        // A response arriving on the final count still wins over the timeout.
        if (resp_rdy) begin
          resp_d  = resp;
          state_d = S_CHECK;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          code_d  = 2'b10;
          state_d = S_ERR;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_CHECK: begin
        if (resp_q == ACK) begin
          dly_cnt_d = dly_q;
          state_d   = S_SETTLE;
        end else begin
          err_d   = 1'b1;
          code_d  = 2'b01;
          state_d = S_ERR;
        end
      end
      S_SETTLE: begin
        if (dly_cnt_q != '0) begin
          dly_cnt_d = dly_cnt_q - DLY_W'(1);
        end else if (!last) begin
          idx_d   = idx_q + AW'(1);
          state_d = S_LOAD;
        end else begin
          if (pass_q != 16'hFFFF) pass_d = pass_q + 16'd1;
          if (loop_q) begin
            idx_d   = '0;
            state_d = S_LOAD;
          end else begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (busy && abort) begin
      err_d   = 1'b1;
      code_d  = 2'b11;
      state_d = S_ERR;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cmd_q     <= '0;
      dat_q     <= '0;
      dly_q     <= '0;
      dly_cnt_q <= '0;
      tmo_q     <= '0;
      resp_q    <= '0;
      num_q     <= '0;
      loop_q    <= 1'b0;
      idx_q     <= '0;
      pass_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= 2'b00;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      dat_q     <= dat_d;
      dly_q     <= dly_d;
      dly_cnt_q <= dly_cnt_d;
      tmo_q     <= tmo_d;
      resp_q    <= resp_d;
      num_q     <= num_d;
      loop_q    <= loop_d;
      idx_q     <= idx_d;
      pass_q    <= pass_d;
      done_q    <= done_d;
      err_q     <= err_d;
      code_q    <= code_d;
    end
  end

  // Abort suppresses the send and the clear in the very cycle it is seen.
  assign send_cmd     = (state_q == S_SEND) && !abort;
  assign clr_resp_rdy = (state_q == S_WAIT_RESP) && resp_rdy && !abort;
  assign host_cmd     = cmd_q;
  assign data         = dat_q;
  assign done         = done_q;
  assign err          = err_q;
  assign err_code     = code_q;
  assign cur_idx      = idx_q;
  assign pass_cnt     = pass_q;
endmodule

// File: doc/remote_cmd_sequencer.md
Name: remote_cmd_sequencer

Overview:
- Synthesizable host-side command player that drives a RemoteComm master (cmd/data/send_cmd handshake) from a programmable table of (cmd, data, settle-delay) entries.
- Generalises the hand-scripted calibrate/thrust/pitch/roll/yaw/land sequences into a depth-parametrised, self-checking engine.
- Adds response checking against an ACK code, a response timeout, abort, and loop mode with a pass counter.
- Sits between on-board or bench control logic and RemoteComm in flight-sequence regression and HIL setups.

Parameters:
DEPTH, 16, number of table entries (power of 2, >=2)
CMD_W, 8, command field width
DATA_W, 16, data field width
DLY_W, 24, settle-delay field width (clock cycles)
TMO_CYC, 2000000, response timeout in cycles after cmd_sent
ACK, 8'hA5, expected positive response byte

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
wr_en  in  1  table write strobe (ignored while busy)
wr_addr  in  $clog2(DEPTH)  table write address
wr_cmd  in  CMD_W  command to store
wr_data  in  DATA_W  data to store
wr_dly  in  DLY_W  post-ACK settle cycles to store
num_entries  in  $clog2(DEPTH)+1  entries to play (sampled on start)
start  in  1  begin playback (honoured in IDLE, DONE, ERR)
abort  in  1  stop playback
loop_en  in  1  wrap to entry 0 after last entry (sampled on start)
host_cmd  out  CMD_W  command to RemoteComm
data  out  DATA_W  data to RemoteComm
send_cmd  out  1  one-cycle send pulse
cmd_sent  in  1  RemoteComm transmission complete
resp_rdy  in  1  RemoteComm response valid
resp  in  8  response byte
clr_resp_rdy  out  1  one-cycle clear of resp_rdy
busy  out  1  playback in progress
done  out  1  sequence completed cleanly (level)
err  out  1  sequence halted on error (level)
err_code  out  2  01 NAK, 10 timeout, 11 abort
cur_idx  out  $clog2(DEPTH)  entry in progress / failing entry
pass_cnt  out  16  completed loop passes, saturating

Behaviour:
- Reset: state IDLE; all outputs 0; table contents undefined (not reset).
- Table write: synchronous, one entry per cycle when wr_en=1 and busy=0; a write while busy is dropped.
- States: IDLE, LOAD, SEND, WAIT_SENT, WAIT_RESP, CHECK, SETTLE, DONE, ERR.
- IDLE/DONE/ERR + start:
  - num_entries=0: -> DONE next cycle.
  - Otherwise: latch num_entries and loop_en; cur_idx=0; pass_cnt=0; clear done/err/err_code; -> LOAD.
- LOAD: register table[cur_idx] onto host_cmd/data/delay (1 cycle, sync-read friendly) -> SEND.
- SEND:
  - send_cmd=1 for exactly one cycle -> WAIT_SENT.
  - host_cmd/data stay stable until the next LOAD.
- WAIT_SENT: on cmd_sent=1 -> WAIT_RESP; clear the timeout counter.
- WAIT_RESP:
  - Counter increments each cycle.
  - resp_rdy=1: clr_resp_rdy=1 that cycle; capture resp -> CHECK.
  - Counter reaches TMO_CYC-1 without resp_rdy: -> ERR, err_code=10.
  - resp_rdy in the same cycle as the final count: resp wins.
- CHECK:
  - resp==ACK: -> SETTLE, loading the delay counter.
  - Otherwise: -> ERR, err_code=01.
- SETTLE:
  - Counts delay cycles; delay=0 means zero settle cycles, advancing on the first SETTLE cycle.
  - Not last entry: cur_idx+1 -> LOAD.
  - Last entry (cur_idx==num_entries-1), loop_en=1: pass_cnt+1 (saturates at FFFF); cur_idx=0 -> LOAD.
  - Last entry, loop_en=0: pass_cnt+1 -> DONE.
- Entry latency: ACK to next send_cmd = delay+3 cycles (SETTLE exit, LOAD, SEND).
- DONE: done=1, busy=0, until the next start.
- ERR: err=1, busy=0; cur_idx holds the failing entry until the next start.
- busy=1 in every state except IDLE, DONE, and ERR.
- Abort in any busy state: -> ERR next cycle, err_code=11; no further send_cmd. An in-flight RemoteComm frame completes on its own and its response is discarded.
- Abort has priority over start, resp_rdy, and timeout in the same cycle.
- Abort while not busy: ignored.
- Start while busy: ignored.
- Reset mid-operation: immediate return to IDLE on the next clk edge; outputs 0.
- resp_rdy outside WAIT_RESP: ignored; clr_resp_rdy not asserted.

Test Plan:
- Load 3 entries (06/0000 dly 0; 05/00FF dly 100; 02/0100 dly 0), num_entries=3, start; model ACKs A5 -> three send_cmd pulses carrying those cmd/data in order; 103 cycles from 2nd ACK to 3rd send_cmd; done=1, pass_cnt=1, err=0.
- Entry 1 answered with 5A -> err=1, err_code=01, cur_idx=1, no third send_cmd.
- Model never raises resp_rdy, TMO_CYC=50 -> err_code=10, exactly 50 cycles after cmd_sent.
- loop_en=1, 2 entries, 4 full passes then abort during WAIT_SENT -> pass_cnt=4, err_code=11, no send_cmd after abort.
- num_entries=0 start -> done next cycle, no send_cmd.
- wr_en during playback to the active entry -> playback uses the original values.
- rst_n low for 1 cycle mid-SETTLE -> all outputs 0 next cycle; a subsequent start replays from entry 0.
